axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter
Interface
REQ-001 Parameters: none; all widths fixed as listed.
REQ-002 aclk  input  1  single clock; all state changes on its rising edge.
REQ-003 aresetn  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  1  instruction-side read request; held until i_ack.
REQ-005 i_addr  input  32  instruction read byte address.
REQ-006 i_len  input  8  instruction burst length minus one.
REQ-007 i_ack  output  1  one-cycle pulse when the instruction AR handshake completes.
REQ-008 i_rvalid  output  1  read beat for instruction side valid this cycle.
REQ-009 d_req  input  1  data-side read request; held until d_ack.
REQ-010 d_addr  input  32  data read byte address.
REQ-011 d_len  input  8  data burst length minus one.
REQ-012 d_size  input  3  data beat size, AXI encoding.
REQ-013 d_ack  output  1  one-cycle pulse when the data AR handshake completes.
REQ-014 d_rvalid  output  1  read beat for data side valid this cycle.
REQ-015 req_rdata  output  32  read data, shared by both requesters.
REQ-016 req_rresp  output  2  read response, shared.
REQ-017 req_rlast  output  1  last beat flag, shared.
REQ-018 arid  output  4  4'd0 instruction, 4'd1 data.
REQ-019 araddr  output  32  AXI read address.
REQ-020 arlen  output  8  AXI burst length.
REQ-021 arsize  output  3  AXI beat size.
REQ-022 arvalid  output  1  AXI AR valid.
REQ-023 arready  input  1  AXI AR ready.
REQ-024 rdata  input  32  AXI read data.
REQ-025 rresp  input  2  AXI read response.
REQ-026 rlast  input  1  AXI last beat.
REQ-027 rvalid  input  1  AXI read valid.
REQ-028 rready  output  1  AXI read ready.
Function
REQ-029 FSM states IDLE, ADDR, DATA; one transaction outstanding at a time; arburst/arlock/arcache/arprot are tied off outside this block.
REQ-030 IDLE: if any request sampled at an edge, latch winner, its addr/len/size (instruction size fixed 3'b010) and arid, enter ADDR; arvalid high from the next cycle.
REQ-031 ADDR: arvalid and all AR fields held stable until arvalid&&arready; that cycle pulse winner's x_ack, enter DATA.
REQ-032 DATA: rready=1; x_rvalid of owner = rvalid (combinational, zero latency); req_rdata/req_rresp/req_rlast = rdata/rresp/rlast; non-owner x_rvalid=0.
REQ-033 DATA: rvalid&&rlast returns to IDLE; a pending request is granted at the next edge (AR of next burst no earlier than 2 cycles after last beat).
REQ-034 rready=0 and both x_rvalid=0 in IDLE and ADDR; rvalid there is ignored.
REQ-035 Requests arriving in ADDR/DATA wait; no preemption; rresp errors are forwarded, not acted on.
REQ-036 Default arbitration (macro absent): fixed priority, data over instruction on simultaneous requests.
Reset
REQ-037 aresetn low immediately forces IDLE, arvalid=0, rready=0, x_ack=0, x_rvalid=0, araddr/arlen/arsize/arid=0, round-robin pointer=instruction-last; any burst in flight is abandoned.
Configuration
REQ-038 ARB_RR_EN defined: on simultaneous requests grant the side not granted last (pointer updated at each grant, data wins first after reset); undefined: fixed priority of REQ-036, no pointer.
Verification
REQ-039 i_req, i_addr=0xBFC00000, i_len=7, arready after 2 cycles, 8 beats 0x1..0x8 -> arid=0, arlen=7, arsize=2, one i_ack, 8 i_rvalid pulses, req_rlast with 0x8.
REQ-040 i_req and d_req same cycle, macro absent -> first AR arid=1; second AR arid=0 only after data rlast.
REQ-041 ARB_RR_EN defined, both requesters held high for 4 bursts -> arid sequence 1,0,1,0.
REQ-042 rvalid=1 while in ADDR (arready=0) -> rready=0, i_rvalid=d_rvalid=0.
REQ-043 aresetn low during beat 3 of 8 -> arvalid, rready, x_rvalid all 0 without waiting for a clock edge; after release a new d_req (d_size=2, d_len=0) completes normally with arid=1.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: arbitrates instruction and data read requests onto one AXI read channel, one burst outstanding.
// Optional macro ARB_RR_EN: alternate grants on simultaneous requests; when undefined data has fixed priority.
module axi_rd_arbiter (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [7:0]  i_len,
    output logic        i_ack,
    output logic        i_rvalid,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [7:0]  d_len,
    input  logic [2:0]  d_size,
    output logic        d_ack,
    output logic        d_rvalid,
    output logic [31:0] req_rdata,
    output logic [1:0]  req_rresp,
    output logic        req_rlast,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner_d;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;
    logic        w_gnt;
    logic        w_gnt_d;
    logic        w_take;
    logic        w_ar_done;
    logic        w_data;

    assign w_gnt  = i_req || d_req;
    assign w_take = (r_state == IDLE) && w_gnt;

`ifdef ARB_RR_EN
    logic r_last_d;

    // on a tie the data side wins unless it also won the previous grant
    always_comb w_gnt_d = d_req && (!i_req || !r_last_d);

    // remember which side received the most recent grant
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_last_d <= 1'b0;
        else if (w_take)
            r_last_d <= w_gnt_d;
    end
`else
    assign w_gnt_d = d_req;
`endif

    // state register; reset abandons any burst in flight
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // next state: grant in IDLE, wait for AR handshake, then wait for the last beat
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_gnt ? ADDR : IDLE;
            ADDR:    w_state_nxt = arready ? DATA : ADDR;
            DATA:    w_state_nxt = (rvalid && rlast) ? IDLE : DATA;
            default: w_state_nxt = IDLE;
        endcase
    end

    // latch the winner and its AR fields at grant; held stable until the next grant
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_owner_d <= 1'b0;
            r_araddr  <= 32'd0;
            r_arlen   <= 8'd0;
            r_arsize  <= 3'd0;
        end else if (w_take) begin
            r_owner_d <= w_gnt_d;
            r_araddr  <= w_gnt_d ? d_addr : i_addr;
            r_arlen   <= w_gnt_d ? d_len : i_len;
            r_arsize  <= w_gnt_d ? d_size : 3'b010;
        end
    end

    assign arvalid   = (r_state == ADDR);
    assign w_ar_done = arvalid && arready;
    assign w_data    = (r_state == DATA);
    assign arid      = {3'b000, r_owner_d};
    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign arsize    = r_arsize;
    assign i_ack     = w_ar_done && !r_owner_d;
    assign d_ack     = w_ar_done && r_owner_d;
    assign rready    = w_data;
    assign i_rvalid  = w_data && rvalid && !r_owner_d;
    assign d_rvalid  = w_data && rvalid && r_owner_d;
    assign req_rdata = w_data ? rdata : 32'd0;
    assign req_rresp = w_data ? rresp : 2'd0;
    assign req_rlast = w_data && rlast;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed and randomized bench with an AXI slave and arbitration model.
module tb_axi_rd_arbiter;
    logic        aclk;
    logic        aresetn;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr;
    logic [7:0]  i_len, d_len;
    logic [2:0]  d_size;
    logic        i_ack, d_ack, i_rvalid, d_rvalid;
    logic [31:0] req_rdata;
    logic [1:0]  req_rresp;
    logic        req_rlast;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    int checks = 0;
    int errors = 0;
    bit m_last_d = 0;
    int cnt_iack = 0;
    int cnt_irv = 0;

    axi_rd_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_ack(i_ack), .i_rvalid(i_rvalid),
        .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_size(d_size), .d_ack(d_ack), .d_rvalid(d_rvalid),
        .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // winner on a request pattern: data alone or instruction alone wins; on a tie,
    // fixed build always picks data, round-robin build picks the side not granted last
    function automatic bit pick(input bit ir, input bit dr);
        if (ir && dr) begin
`ifdef ARB_RR_EN
            return !m_last_d;
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    // AXI slave for one burst; starts in the IDLE cycle where the request is sampled
    task automatic serve(input int ar_dly, input bit keep, input bit seq, input int abort_beat,
                         output logic [3:0] id);
        int w;
        bit ed;
        logic [31:0] ea, dat;
        logic [7:0] el;
        logic [2:0] es;
        logic [1:0] rs;
        id = 4'hf;
        #1 chk("ar_early", arvalid, 0);
        tick();
        w = 0;
        while (w <= 20) begin
            #1;
            if (arvalid) break;
            w++;
            tick();
        end
        chk("ar_latency", w, 0);
        if (w > 20) return;
        ed = pick(i_req, d_req);
        ea = ed ? d_addr : i_addr;
        el = ed ? d_len : i_len;
        es = ed ? d_size : 3'd2;
        id = arid;
        chk("arid", arid, {3'b000, ed});
        chk("araddr", araddr, ea);
        chk("arlen", arlen, el);
        chk("arsize", arsize, es);
        m_last_d = ed;
        for (int k = 0; k < ar_dly; k++) begin
            rvalid = 1; rdata = $urandom; rlast = 1;
            #1 chk("addr_quiet", {rready, i_rvalid, d_rvalid, i_ack, d_ack}, 0);
            chk("ar_hold_valid", arvalid, 1);
            chk("ar_hold_addr", araddr, ea);
            chk("ar_hold_len", arlen, el);
            tick();
        end
        rvalid = 0; rlast = 0; arready = 1;
        #1 chk("i_ack", i_ack, !ed);
        chk("d_ack", d_ack, ed);
        cnt_iack += i_ack;
        tick();
        arready = 0;
        if (!keep) begin
            if (ed) d_req = 0;
            else i_req = 0;
        end
        for (int b = 0; b <= int'(el); b++) begin
            repeat ($urandom_range(0, 2)) begin
                rvalid = 0;
                #1 chk("gap_rvalid", {i_rvalid, d_rvalid}, 0);
                chk("gap_rready", rready, 1);
                tick();
            end
            dat = seq ? b + 1 : $urandom;
            rs = 2'($urandom);
            rvalid = 1; rdata = dat; rresp = rs; rlast = (b == int'(el));
            if (b == abort_beat) begin
                #1 chk("pre_rst_rvalid", {i_rvalid, d_rvalid}, {!ed, ed});
                aresetn = 0;
                #1 chk("rst_async", {arvalid, rready, i_rvalid, d_rvalid, i_ack, d_ack}, 0);
                chk("rst_ar_fields", {arid, arlen, arsize}, 0);
                chk("rst_araddr", araddr, 0);
                rvalid = 0; rlast = 0; i_req = 0; d_req = 0; m_last_d = 0;
                tick();
                aresetn = 1;
                return;
            end
            #1 chk("i_rvalid", i_rvalid, !ed);
            chk("d_rvalid", d_rvalid, ed);
            chk("req_rdata", req_rdata, dat);
            chk("req_rresp", req_rresp, rs);
            chk("req_rlast", req_rlast, b == int'(el));
            chk("rready", rready, 1);
            cnt_irv += i_rvalid;
            tick();
        end
        rvalid = 0; rlast = 0;
    endtask

    initial begin
        logic [3:0] id;
        logic [3:0] ids [4];
        int p;
        aresetn = 0; i_req = 0; d_req = 0; i_addr = 0; d_addr = 0; i_len = 0; d_len = 0; d_size = 0;
        arready = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        #1 chk("reset_out", {arvalid, rready, i_ack, d_ack, i_rvalid, d_rvalid}, 0);
        chk("reset_ar", {arid, arlen, arsize}, 0);
        chk("reset_araddr", araddr, 0);
        @(negedge aclk);
        tick();
        aresetn = 1;

        // single instruction burst of 8 beats
        i_addr = 32'hBFC00000; i_len = 7; i_req = 1; cnt_iack = 0; cnt_irv = 0;
        serve(2, 0, 1, -1, id);
        chk("t1_arid", id, 0);
        chk("t1_ack_count", cnt_iack, 1);
        chk("t1_beat_count", cnt_irv, 8);

        // simultaneous requests: data first, instruction only after data rlast
        i_addr = $urandom; i_len = 8'($urandom_range(0, 3));
        d_addr = $urandom; d_len = 8'($urandom_range(0, 3)); d_size = 3'($urandom_range(0, 2));
        i_req = 1; d_req = 1;
        serve(1, 0, 0, -1, id);
        chk("t2_first_arid", id, 1);
        serve(0, 0, 0, -1, id);
        chk("t2_second_arid", id, 0);

        // both requesters held high across four bursts after a fresh reset
        aresetn = 0; tick(); aresetn = 1; m_last_d = 0;
        i_len = 1; d_len = 2;
        i_req = 1; d_req = 1;
        for (int k = 0; k < 4; k++) serve($urandom_range(0, 2), 1, 0, -1, ids[k]);
        i_req = 0; d_req = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            chk($sformatf("t3_seq%0d", k), ids[k], (k % 2 == 0) ? 1 : 0);
`else
            chk($sformatf("t3_seq%0d", k), ids[k], 1);
`endif
        end
        tick();

        // randomized request patterns
        for (int n = 0; n < 10; n++) begin
            p = $urandom_range(1, 3);
            i_addr = $urandom; i_len = 8'($urandom_range(0, 4));
            d_addr = $urandom; d_len = 8'($urandom_range(0, 4)); d_size = 3'($urandom_range(0, 2));
            i_req = p[0]; d_req = p[1];
            for (int s = 0; s < 2 && (i_req || d_req); s++) serve($urandom_range(0, 3), 0, 0, -1, id);
            i_req = 0; d_req = 0;
            repeat ($urandom_range(0, 2)) tick();
        end

        // reset during beat 3 of 8, then a normal single-beat data read
        i_addr = $urandom; i_len = 7; i_req = 1;
        serve(1, 0, 0, 2, id);
        d_addr = $urandom; d_size = 2; d_len = 0; d_req = 1;
        serve(0, 0, 0, -1, id);
        chk("t5_arid", id, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
